// File: rtl/arb_mux_reg.sv
// N-channel mux with explicit-select or round-robin arbitration into a single output register.
// Latency: one cycle from the accepting edge to out_valid/out_data/out_src.
// Backpressure: a held output (out_valid && !out_ready) blocks loading and drives in_ready to zero.
module arb_mux_reg #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SEL_W-1:0]   sel,
  input  logic               mode,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   out_src
);

  logic             load_en;
  logic             grant_valid;
  logic [SEL_W-1:0] grant;
  logic [WIDTH-1:0] grant_data;
  logic             xfer;
  logic [SEL_W-1:0] ptr;

  // The output register can take a new item when it is empty or being drained.
  assign load_en = !out_valid || out_ready;
  assign xfer    = load_en && grant_valid;

  // Grant selection. Explicit select only matches legal channel indices, so an
  // out-of-range sel yields no grant. Round-robin takes the lowest valid index
  // at or above ptr, otherwise wraps to the lowest valid index below ptr.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    if (!mode) begin
      for (int i = 0; i < N; i++) begin
        if (sel == SEL_W'(i)) begin
          grant       = SEL_W'(i);
          grant_valid = in_valid[i];
        end
      end
    end else begin
      // Wrapped candidates first, in descending order, so later passes override.
      for (int i = N - 1; i >= 0; i--) begin
        if (in_valid[i] && (SEL_W'(i) < ptr)) begin
          grant = SEL_W'(i);
        end
      end
      for (int i = N - 1; i >= 0; i--) begin
        if (in_valid[i] && (SEL_W'(i) >= ptr)) begin
          grant = SEL_W'(i);
        end
      end
      grant_valid = |in_valid;
    end
  end

  // Data mux driven by the grant index; only legal indices ever match.
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == SEL_W'(i)) begin
        grant_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // One-hot accept on the granted channel; forced low while reset is asserted.
  always_comb begin
    in_ready = '0;
    if (rst_n && xfer) begin
      in_ready = {{(N-1){1'b0}}, 1'b1} << grant;
    end
  end

  // Round-robin pointer advances past the winner only on a round-robin transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (xfer && mode) begin
      ptr <= (grant == SEL_W'(N - 1)) ? '0 : grant + 1'b1;
    end
  end

  // Output register: load on transfer, drop valid when drained, hold when stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (load_en) begin
      if (grant_valid) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_src   <= grant;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arb_mux_reg.sv
// Directed bench for arb_mux_reg: a 4-channel and a 3-channel instance on a shared clock/reset.
// Inputs are driven 2 time units after the rising edge; outputs are sampled 1 unit later.
// Expected values are hand-computed constants.
module tb_arb_mux_reg;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 4-channel instance
  logic [31:0] a_in_data;
  logic [3:0]  a_in_valid, a_in_ready;
  logic [1:0]  a_sel, a_out_src;
  logic        a_mode, a_out_valid, a_out_ready;
  logic [7:0]  a_out_data;

  // 3-channel instance
  logic [23:0] b_in_data;
  logic [2:0]  b_in_valid, b_in_ready;
  logic [1:0]  b_sel, b_out_src;
  logic        b_mode, b_out_valid, b_out_ready;
  logic [7:0]  b_out_data;

  int checks   = 0;
  int failures = 0;

  arb_mux_reg #(.WIDTH(8), .N(4)) u_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .sel(a_sel), .mode(a_mode), .out_data(a_out_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_src(a_out_src)
  );

  arb_mux_reg #(.WIDTH(8), .N(3)) u_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .sel(b_sel), .mode(b_mode), .out_data(b_out_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_src(b_out_src)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to 2 units past the next rising edge (input drive point).
  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Let combinational paths settle after driving inputs.
  task automatic settle;
    #1;
  endtask

  initial begin
    // Reset with all channels requesting: in_ready must stay low.
    rst_n       = 1'b0;
    a_in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
    a_in_valid  = 4'b1111;
    a_sel       = 2'd0;
    a_mode      = 1'b0;
    a_out_ready = 1'b1;
    b_in_data   = {8'h32, 8'h31, 8'h30};
    b_in_valid  = 3'b000;
    b_sel       = 2'd0;
    b_mode      = 1'b0;
    b_out_ready = 1'b1;
    #3;
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_data",  a_out_data, 0);
    chk("rst_out_src",   a_out_src, 0);
    chk("rst_in_ready",  a_in_ready, 0);
    tick();
    chk("rst_in_ready_hold", a_in_ready, 0);
    a_in_valid = 4'b0000;
    #1 rst_n = 1'b1;
    tick();

    // Explicit select of channel 2.
    a_in_data  = {8'h13, 8'hA5, 8'h11, 8'h10};
    a_sel      = 2'd2;
    a_in_valid = 4'b0100;
    settle();
    chk("m0_in_ready", a_in_ready, 4'b0100);
    tick();
    chk("m0_out_data",  a_out_data, 8'hA5);
    chk("m0_out_src",   a_out_src, 2);
    chk("m0_out_valid", a_out_valid, 1);
    a_in_valid = 4'b0000;
    tick();
    chk("drain_valid", a_out_valid, 0);
    chk("drain_data_hold", a_out_data, 8'hA5);

    // Round-robin from ptr=0 with all channels valid.
    a_in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    a_mode     = 1'b1;
    a_in_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("rr_in_ready", a_in_ready, 4'b0001 << (k % 4));
      tick();
      chk("rr_out_src",  a_out_src, k % 4);
      chk("rr_out_data", a_out_data, 8'h10 + (k % 4));
    end

    // ptr=1: load 3C from channel 1, then stall for 3 cycles.
    a_in_data = {8'h13, 8'h12, 8'h3C, 8'h10};
    tick();
    chk("hold_load_data", a_out_data, 8'h3C);
    a_out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("hold_in_ready", a_in_ready, 0);
      tick();
      chk("hold_data",  a_out_data, 8'h3C);
      chk("hold_valid", a_out_valid, 1);
      chk("hold_src",   a_out_src, 1);
    end
    a_out_ready = 1'b1;
    settle();
    chk("resume_in_ready", a_in_ready, 4'b0100);
    tick();
    chk("resume_src",  a_out_src, 2);
    chk("resume_data", a_out_data, 8'h12);

    // ptr=3 with only channels 0,1 valid: wrap to 0, then 1.
    a_in_valid = 4'b0011;
    settle();
    chk("wrap_in_ready0", a_in_ready, 4'b0001);
    tick();
    chk("wrap_src0", a_out_src, 0);
    settle();
    chk("wrap_in_ready1", a_in_ready, 4'b0010);
    tick();
    chk("wrap_src1", a_out_src, 1);

    // Mode switch while stalled must not disturb the pending item.
    a_out_ready = 1'b0;
    a_mode      = 1'b0;
    a_sel       = 2'd3;
    a_in_valid  = 4'b1000;
    settle();
    chk("sw_in_ready_stall", a_in_ready, 0);
    tick();
    chk("sw_hold_src",  a_out_src, 1);
    chk("sw_hold_data", a_out_data, 8'h3C);
    a_out_ready = 1'b1;
    settle();
    chk("sw_in_ready", a_in_ready, 4'b1000);
    tick();
    chk("sw_src", a_out_src, 3);
    // Mode-0 transfer left ptr at 2.
    a_mode     = 1'b1;
    a_in_valid = 4'b1111;
    settle();
    chk("ptr_held_in_ready", a_in_ready, 4'b0100);

    // Load FF from channel 2 (ptr becomes 3), then reset mid-cycle.
    a_in_data = {8'h13, 8'hFF, 8'h11, 8'h10};
    tick();
    chk("pre_rst_data",  a_out_data, 8'hFF);
    chk("pre_rst_valid", a_out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", a_out_valid, 0);
    chk("async_rst_data",  a_out_data, 0);
    chk("async_rst_src",   a_out_src, 0);
    chk("async_rst_in_ready", a_in_ready, 0);
    #1 rst_n = 1'b1;
    settle();
    chk("ptr_restart_in_ready", a_in_ready, 4'b0001);
    tick();
    chk("ptr_restart_src", a_out_src, 0);
    a_in_valid = 4'b0000;
    tick();

    // N=3: out-of-range select gives no transfer.
    b_sel      = 2'd3;
    b_in_valid = 3'b111;
    settle();
    chk("n3_sel3_in_ready", b_in_ready, 0);
    tick();
    chk("n3_sel3_valid", b_out_valid, 0);

    // N=3 round-robin: 0,1,2 then exact wrap to 0.
    b_mode = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("n3_rr_in_ready", b_in_ready, 3'b001 << (k % 3));
      tick();
      chk("n3_rr_src",  b_out_src, k % 3);
      chk("n3_rr_data", b_out_data, 8'h30 + (k % 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arb_mux_reg.md
ARB_MUX_REG -- requirements
Module: arb_mux_reg

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits per channel.
REQ-002 Parameter N, default 4, number of input channels (N >= 2).
REQ-003 Derived localparam SEL_W = clog2(N), select and source-tag width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_data  input  N*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  N  per-channel data-valid.
REQ-008 in_ready  output  N  per-channel accept; combinational.
REQ-009 sel  input  SEL_W  explicit channel select, used only when mode = 0.
REQ-010 mode  input  1  0 = explicit select, 1 = round-robin arbitration.
REQ-011 out_data  output  WIDTH  registered selected data.
REQ-012 out_valid  output  1  out_data/out_src hold a pending item.
REQ-013 out_ready  input  1  downstream accept.
REQ-014 out_src  output  SEL_W  index of the channel that supplied out_data.

Function
REQ-015 Output stage SHALL be a single register; load_en = (!out_valid || out_ready).
REQ-016 Transfer on channel g SHALL occur when load_en && grant_valid && grant = g; then in_ready[g] = 1, all other in_ready bits = 0.
REQ-017 in_ready SHALL be all-zero whenever load_en = 0 or no grant exists; in_ready SHALL NOT depend on out_data contents.
REQ-018 Mode 0: grant = sel, grant_valid = in_valid[sel]; sel >= N SHALL yield no grant (no transfer, no X propagation).
REQ-019 Mode 1: grant = first i with in_valid[i] = 1 searching ptr, ptr+1, ..., wrapping modulo N; grant_valid = |in_valid.
REQ-020 Round-robin pointer ptr (SEL_W bits) SHALL update to (grant+1) mod N only on a mode-1 transfer; wrap from N-1 to 0 SHALL be exact for non-power-of-2 N.
REQ-021 ptr SHALL hold its value during mode-0 operation and on cycles with no transfer.
REQ-022 mode and sel SHALL take effect combinationally in the same cycle; switching mode mid-stream SHALL NOT corrupt a pending output item.
REQ-023 On transfer, out_data <= channel g data, out_src <= g, out_valid <= 1, visible the cycle after the accepting edge (latency 1).
REQ-024 When out_valid && out_ready and no new transfer, out_valid SHALL clear next cycle; out_data/out_src hold last value.
REQ-025 When out_valid && !out_ready, out_data, out_src, out_valid SHALL be held stable (no overwrite, no drop).
REQ-026 Sustained throughput SHALL be one item per cycle while out_ready = 1 and a grant exists.

Reset
REQ-027 rst_n low SHALL immediately (asynchronously) force out_valid = 0, out_data = 0, out_src = 0, ptr = 0.
REQ-028 While rst_n low, in_ready SHALL be all-zero.
REQ-029 Reset deassertion SHALL be sampled synchronously; first possible transfer on the first rising edge with rst_n high.
REQ-030 Reset asserted while out_valid = 1 SHALL discard the pending item; no transfer completes in that cycle.

Verification
REQ-031 N=4, WIDTH=8, mode 0, sel=2, in_valid=4'b0100, in_data ch2=8'hA5, out_ready=1 -> in_ready=4'b0100; next cycle out_data=8'hA5, out_src=2, out_valid=1.
REQ-032 Mode 1, ptr=0, in_valid=4'b1111 held, out_ready=1 for 5 cycles -> out_src sequence 0,1,2,3,0; in_ready one-hot each cycle.
REQ-033 Mode 1, ptr=3, in_valid=4'b0011 -> grant ch0 (wrap), ptr becomes 1; next grant ch1, ptr becomes 2.
REQ-034 Output holding 8'h3C with out_ready=0 for 3 cycles, in_valid=4'b1111 -> in_ready=0, out_data stays 8'h3C; on out_ready=1 new item loads the following cycle.
REQ-035 N=3 build, mode 0, sel=3 with in_valid=3'b111 -> no transfer, in_ready=0, out_valid stays 0; mode 1 ptr wraps 2->0.
REQ-036 rst_n pulsed low mid-stream with out_valid=1, out_data=8'hFF -> out_valid=0, out_data=0, out_src=0 before next clock edge; ptr restarts at 0.
